cr_xp10_decomp_be_ob_arb: RTL and testbench
===========================================

Name: cr_xp10_decomp_be_ob_arb

Overview:
- Output arbiter directly downstream of the decompressor back-end FIFO stage.
- Drains two show-ahead FIFOs:
  - the pass-through TLV FIFO, which carries headers, footers-bypass and non-LZ TLVs;
  - the LZ data FIFO, which carries reassembled DATA_UNK frames plus modified footers.
- Merges both into one ordered valid/ready output stream.
- Ordering is fixed by single-word "LZ slot" marker TLVs in the pass-through stream. Each marker is replaced by exactly one complete LZ-side frame (sot..eot).

Parameters:
- DW, 64, payload width of TLV data words (tdata only; sideband travels on separate ports).
- CNT_W, 16, width of the LZ frame statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- pt_empty  in  1  pass-through FIFO empty
- pt_rd  out  1  pass-through FIFO pop
- pt_rdata  in  DW  pass-through head word (valid when !pt_empty)
- pt_sot  in  1  head word is first word of TLV
- pt_eot  in  1  head word is last word of TLV
- pt_lz_slot  in  1  head word is an LZ slot marker
- lz_empty  in  1  LZ data FIFO empty
- lz_rd  out  1  LZ data FIFO pop
- lz_rdata  in  DW  LZ head word
- lz_sot  in  1  LZ head word starts frame
- lz_eot  in  1  LZ head word ends frame
- ob_valid  out  1  output word valid
- ob_ready  in  1  downstream accept
- ob_data  out  DW  output word
- ob_sot  out  1  output sot
- ob_eot  out  1  output eot
- ob_src  out  1  0 = pass-through, 1 = LZ
- clear_err  in  1  clears sticky error flags
- err_pt_sync  out  1  sticky: pass-through word without sot seen in PT_SOT
- err_lz_sync  out  1  sticky: LZ framing violation
- stat_lz_frames  out  CNT_W  count of LZ frames forwarded

Behaviour:
- Reset:
  - ob_valid=0, ob_data/ob_sot/ob_eot/ob_src=0.
  - pt_rd=lz_rd=0, both error flags 0, stat_lz_frames=0.
  - FSM in PT_SOT, skid buffer empty.
  - External FIFOs are not flushed. Reset mid-frame abandons the frame; the next pass-through word must carry sot.
- Output pipeline:
  - Output register plus one-entry skid buffer.
  - can_pop = !skid_valid.
  - A popped, forwarded word reaches ob_valid the next cycle (latency 1).
  - If ob_valid && !ob_ready when a word is popped, the word goes to the skid. The skid drains to the output register when ob_ready is seen.
  - At most one pop per cycle total; pt_rd and lz_rd are never both high.
  - pt_rd and lz_rd are combinational: pop = state-selected !empty && can_pop.
  - A word is never dropped or duplicated under backpressure. Output fields are held stable while ob_valid && !ob_ready.
- FSM states: PT_SOT, PT_BODY, LZ_SOT, LZ_BODY.
  - PT_SOT, on a pop:
    - pt_lz_slot && pt_sot && pt_eot: consume the marker without forwarding, go to LZ_SOT.
    - Otherwise pt_sot: forward with ob_src=0. Stay if pt_eot, else go to PT_BODY.
    - !pt_sot: drop the word and set err_pt_sync.
  - PT_BODY: forward each word. pt_lz_slot is ignored. Go to PT_SOT on pt_eot.
  - LZ_SOT, on a pop:
    - lz_sot: forward with ob_src=1. Go to PT_SOT if lz_eot, else to LZ_BODY.
    - !lz_sot: drop the word and set err_lz_sync.
  - LZ_BODY:
    - Forward each word; go to PT_SOT on lz_eot.
    - A word with lz_sot is forwarded with ob_sot forced to 0 and sets err_lz_sync.
  - pt FIFO is never popped in LZ_* states; lz FIFO is never popped in PT_* states. A non-empty other FIFO does not stall progress.
- Counter: stat_lz_frames increments when a word with lz_eot is popped in LZ_SOT or LZ_BODY. Wraps 2^CNT_W-1 -> 0.
- Errors: error flags are sticky. clear_err clears them next cycle. If a set and clear_err occur in the same cycle, set wins.

Test Plan:
- Pass-through only: 3-word TLV (sot, -, eot) with ob_ready=1 -> ob_valid 3 consecutive cycles starting 1 cycle after first pt_rd; ob_src=0; ob_sot/ob_eot on words 1/3.
- Marker plus LZ frame: pass-through [marker, 2-word TLV], LZ [4-word frame] -> output LZ words 1..4 (ob_src=1) then pass-through TLV; marker never appears; stat_lz_frames=1.
- Backpressure: ob_ready toggled 1,0,0,1 repeatedly during a 6-word LZ frame -> all 6 words emitted in order, no duplicates; lz_rd never high while skid full.
- LZ sync: in LZ_SOT, head word has lz_sot=0 -> word dropped, err_lz_sync=1 next cycle. Then clear_err pulse -> err_lz_sync=0.
- Counter wrap: CNT_W=4, 17 single-word LZ frames each preceded by a marker -> stat_lz_frames ends at 1.
- Reset mid-LZ_BODY: assert rst_n low after 2 of 5 LZ words -> outputs zeroed immediately; after release, FSM in PT_SOT and pt FIFO polled first.

Source files
------------

// File: rtl/cr_xp10_decomp_be_ob_arb.sv
// Merges the pass-through TLV FIFO and the LZ data FIFO into one ordered stream; each LZ slot marker is replaced by one LZ frame.
// Latency 1 from pop to ob_valid; output register plus one-entry skid, pops stall only while the skid holds a word.
module cr_xp10_decomp_be_ob_arb #(
   parameter int DW    = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pt_empty,
   output logic             pt_rd,
   input  logic [DW-1:0]    pt_rdata,
   input  logic             pt_sot,
   input  logic             pt_eot,
   input  logic             pt_lz_slot,
   input  logic             lz_empty,
   output logic             lz_rd,
   input  logic [DW-1:0]    lz_rdata,
   input  logic             lz_sot,
   input  logic             lz_eot,
   output logic             ob_valid,
   input  logic             ob_ready,
   output logic [DW-1:0]    ob_data,
   output logic             ob_sot,
   output logic             ob_eot,
   output logic             ob_src,
   input  logic             clear_err,
   output logic             err_pt_sync,
   output logic             err_lz_sync,
   output logic [CNT_W-1:0] stat_lz_frames
);

   localparam logic [1:0] PT_SOT  = 2'd0;
   localparam logic [1:0] PT_BODY = 2'd1;
   localparam logic [1:0] LZ_SOT  = 2'd2;
   localparam logic [1:0] LZ_BODY = 2'd3;

   logic [1:0]    state, state_nxt;
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic          skid_sot, skid_eot, skid_src;
   logic          can_pop;
   logic          fwd;
   logic [DW-1:0] in_data;
   logic          in_sot, in_eot, in_src;
   logic          set_pt_err, set_lz_err, cnt_inc;

   // state[1] selects the LZ side; the other FIFO is never looked at
   assign can_pop = !skid_valid;
   assign pt_rd   = rst_n && !state[1] && !pt_empty && can_pop;
   assign lz_rd   = rst_n &&  state[1] && !lz_empty && can_pop;

   always_comb begin
      state_nxt  = state;
      fwd        = 1'b0;
      in_data    = pt_rdata;
      in_sot     = pt_sot;
      in_eot     = pt_eot;
      in_src     = 1'b0;
      set_pt_err = 1'b0;
      set_lz_err = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         PT_SOT: begin
            if (pt_rd) begin
               if (pt_lz_slot && pt_sot && pt_eot) begin
                  state_nxt = LZ_SOT;
               end else if (pt_sot) begin
                  fwd       = 1'b1;
                  state_nxt = pt_eot ? PT_SOT : PT_BODY;
               end else begin
                  set_pt_err = 1'b1;
               end
            end
         end
         PT_BODY: begin
            if (pt_rd) begin
               fwd = 1'b1;
               if (pt_eot) state_nxt = PT_SOT;
            end
         end
         LZ_SOT: begin
            in_data = lz_rdata;
            in_sot  = lz_sot;
            in_eot  = lz_eot;
            in_src  = 1'b1;
            if (lz_rd) begin
               // any popped eot word counts, even one dropped for missing sot
               cnt_inc = lz_eot;
               if (lz_sot) begin
                  fwd       = 1'b1;
                  state_nxt = lz_eot ? PT_SOT : LZ_BODY;
               end else begin
                  set_lz_err = 1'b1;
               end
            end
         end
         default: begin
            in_data = lz_rdata;
            in_sot  = 1'b0;
            in_eot  = lz_eot;
            in_src  = 1'b1;
            if (lz_rd) begin
               fwd        = 1'b1;
               cnt_inc    = lz_eot;
               set_lz_err = lz_sot;
               if (lz_eot) state_nxt = PT_SOT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= PT_SOT;
         err_pt_sync    <= 1'b0;
         err_lz_sync    <= 1'b0;
         stat_lz_frames <= '0;
      end else begin
         state          <= state_nxt;
         err_pt_sync    <= set_pt_err | (err_pt_sync & ~clear_err);
         err_lz_sync    <= set_lz_err | (err_lz_sync & ~clear_err);
         stat_lz_frames <= stat_lz_frames + CNT_W'(cnt_inc);
      end
   end

   // A pop only happens with the skid empty, so skid drain and a new word never collide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ob_valid   <= 1'b0;
         ob_data    <= '0;
         ob_sot     <= 1'b0;
         ob_eot     <= 1'b0;
         ob_src     <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_sot   <= 1'b0;
         skid_eot   <= 1'b0;
         skid_src   <= 1'b0;
      end else if (!ob_valid || ob_ready) begin
         if (skid_valid) begin
            ob_valid   <= 1'b1;
            ob_data    <= skid_data;
            ob_sot     <= skid_sot;
            ob_eot     <= skid_eot;
            ob_src     <= skid_src;
            skid_valid <= 1'b0;
         end else if (fwd) begin
            ob_valid <= 1'b1;
            ob_data  <= in_data;
            ob_sot   <= in_sot;
            ob_eot   <= in_eot;
            ob_src   <= in_src;
         end else begin
            ob_valid <= 1'b0;
         end
      end else if (fwd) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
         skid_sot   <= in_sot;
         skid_eot   <= in_eot;
         skid_src   <= in_src;
      end
   end

endmodule

// File: tb/tb_cr_xp10_decomp_be_ob_arb.sv
// Directed bench for the back-end output arbiter: FIFO models, output scoreboard, table vectors plus corner-case sequences.
module tb_cr_xp10_decomp_be_ob_arb;

   localparam int DW = 64;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sot;
      logic          eot;
      logic          slot;
   } word_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sot;
      logic          eot;
      logic          src;
      int            cyc;
   } outw_t;

   typedef struct packed {
      logic          lz;
      logic          sot;
      logic          eot;
      logic          slot;
      logic [DW-1:0] data;
      logic          exp_fwd;
      logic          exp_sot;
      logic          exp_eot;
      logic          exp_src;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pt_empty, pt_rd, pt_sot, pt_eot, pt_lz_slot;
   logic [DW-1:0] pt_rdata;
   logic          lz_empty, lz_rd, lz_sot, lz_eot;
   logic [DW-1:0] lz_rdata;
   logic          ob_valid, ob_ready, ob_sot, ob_eot, ob_src;
   logic [DW-1:0] ob_data;
   logic          clear_err, err_pt_sync, err_lz_sync;
   logic [15:0]   stat_lz_frames;

   logic          pt_rd4, lz_rd4, ob_valid4, ob_sot4, ob_eot4, ob_src4, err_pt4, err_lz4;
   logic [DW-1:0] ob_data4;
   logic [3:0]    stat4;

   word_t pt_q[$];
   word_t lz_q[$];
   outw_t cap_q[$];
   vec_t  tbl[19];

   logic          pt_hold, lz_hold;
   int            checks, failures, cyc, first_pop;
   int            stab_viol, both_viol, bp_viol, bp_inflight, mirror_viol;
   bit            bp_on, prev_stall;
   logic [DW+2:0] prev_fields;

   always #5 clk = ~clk;

   cr_xp10_decomp_be_ob_arb #(.DW(DW), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .pt_empty(pt_empty), .pt_rd(pt_rd), .pt_rdata(pt_rdata), .pt_sot(pt_sot), .pt_eot(pt_eot), .pt_lz_slot(pt_lz_slot),
      .lz_empty(lz_empty), .lz_rd(lz_rd), .lz_rdata(lz_rdata), .lz_sot(lz_sot), .lz_eot(lz_eot),
      .ob_valid(ob_valid), .ob_ready(ob_ready), .ob_data(ob_data), .ob_sot(ob_sot), .ob_eot(ob_eot), .ob_src(ob_src),
      .clear_err(clear_err), .err_pt_sync(err_pt_sync), .err_lz_sync(err_lz_sync), .stat_lz_frames(stat_lz_frames)
   );

   cr_xp10_decomp_be_ob_arb #(.DW(DW), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .pt_empty(pt_empty), .pt_rd(pt_rd4), .pt_rdata(pt_rdata), .pt_sot(pt_sot), .pt_eot(pt_eot), .pt_lz_slot(pt_lz_slot),
      .lz_empty(lz_empty), .lz_rd(lz_rd4), .lz_rdata(lz_rdata), .lz_sot(lz_sot), .lz_eot(lz_eot),
      .ob_valid(ob_valid4), .ob_ready(ob_ready), .ob_data(ob_data4), .ob_sot(ob_sot4), .ob_eot(ob_eot4), .ob_src(ob_src4),
      .clear_err(clear_err), .err_pt_sync(err_pt4), .err_lz_sync(err_lz4), .stat_lz_frames(stat4)
   );

   function automatic vec_t mk(input logic lz, input logic sot, input logic eot, input logic slot, input logic [DW-1:0] data,
                               input logic f, input logic es, input logic ee, input logic esrc);
      vec_t v;
      v.lz = lz; v.sot = sot; v.eot = eot; v.slot = slot; v.data = data;
      v.exp_fwd = f; v.exp_sot = es; v.exp_eot = ee; v.exp_src = esrc;
      return v;
   endfunction

   function automatic word_t w(input logic [DW-1:0] data, input logic sot, input logic eot, input logic slot);
      word_t r;
      r.data = data; r.sot = sot; r.eot = eot; r.slot = slot;
      return r;
   endfunction

   task automatic drive_heads();
      pt_empty = (pt_q.size() == 0) || pt_hold;
      lz_empty = (lz_q.size() == 0) || lz_hold;
      if (pt_q.size() != 0) {pt_rdata, pt_sot, pt_eot, pt_lz_slot} = pt_q[0];
      else {pt_rdata, pt_sot, pt_eot, pt_lz_slot} = '0;
      if (lz_q.size() != 0) {lz_rdata, lz_sot, lz_eot} = {lz_q[0].data, lz_q[0].sot, lz_q[0].eot};
      else {lz_rdata, lz_sot, lz_eot} = '0;
   endtask

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: sample at the falling edge, apply FIFO pops and output captures just after the rising edge
   task automatic step();
      logic  s_pt, s_lz, s_acc;
      outw_t o;
      @(negedge clk);
      s_pt  = pt_rd;
      s_lz  = lz_rd;
      s_acc = ob_valid && ob_ready;
      o.data = ob_data; o.sot = ob_sot; o.eot = ob_eot; o.src = ob_src; o.cyc = 0;
      if (s_pt && s_lz) both_viol++;
      if (prev_stall && (!ob_valid || {ob_data, ob_sot, ob_eot, ob_src} != prev_fields)) stab_viol++;
      if ({pt_rd4, lz_rd4, ob_valid4, ob_data4, ob_sot4, ob_eot4, ob_src4, err_pt4, err_lz4} !==
          {pt_rd, lz_rd, ob_valid, ob_data, ob_sot, ob_eot, ob_src, err_pt_sync, err_lz_sync}) mirror_viol++;
      prev_stall  = ob_valid && !ob_ready;
      prev_fields = {ob_data, ob_sot, ob_eot, ob_src};
      if (bp_on) begin
         if (s_lz && bp_inflight >= 2) bp_viol++;
         bp_inflight += (s_lz ? 1 : 0) - (s_acc ? 1 : 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_pt && pt_q.size() != 0) begin
         if (first_pop < 0) first_pop = cyc;
         void'(pt_q.pop_front());
      end
      if (s_lz && lz_q.size() != 0) void'(lz_q.pop_front());
      if (s_acc) begin
         o.cyc = cyc;
         cap_q.push_back(o);
      end
      drive_heads();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ob_ready = 1'b1; clear_err = 1'b0; pt_hold = 1'b0; lz_hold = 1'b0;
      pt_q.delete(); lz_q.delete(); cap_q.delete();
      drive_heads();
      prev_stall = 1'b0; bp_on = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      first_pop = -1;
      cap_q.delete();
   endtask

   task automatic run_idle(input string name, input int budget);
      int n = 0;
      while ((pt_q.size() != 0 || lz_q.size() != 0 || ob_valid) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         checks++; failures++;
         $display("FAIL %s timeout actual=%0d cycles required=<%0d", name, n, budget);
      end
   endtask

   initial begin
      int    k;
      word_t wd;
      logic [3:0] bp_pat;
      checks = 0; failures = 0; cyc = 0; first_pop = -1;
      stab_viol = 0; both_viol = 0; bp_viol = 0; bp_inflight = 0; mirror_viol = 0;
      ob_ready = 1'b1; clear_err = 1'b0; pt_hold = 1'b0; lz_hold = 1'b0;
      prev_stall = 1'b0; bp_on = 1'b0; prev_fields = '0;

      // Reset state, with a pass-through word already waiting
      pt_q.push_back(w(64'h1, 1'b1, 1'b1, 1'b0));
      drive_heads();
      #2;
      chk("rst ob_valid", ob_valid, 0);
      chk("rst ob_fields", {ob_data, ob_sot, ob_eot, ob_src}, 0);
      chk("rst pt_rd", pt_rd, 0);
      chk("rst lz_rd", lz_rd, 0);
      chk("rst errs", {err_pt_sync, err_lz_sync}, 0);
      chk("rst stat", stat_lz_frames, 0);

      // Pass-through only: latency and framing
      do_reset();
      pt_q.push_back(w(64'hA0, 1'b1, 1'b0, 1'b0));
      pt_q.push_back(w(64'hA1, 1'b0, 1'b0, 1'b0));
      pt_q.push_back(w(64'hA2, 1'b0, 1'b1, 1'b0));
      drive_heads();
      run_idle("pt3", 50);
      chk("pt3 count", cap_q.size(), 3);
      for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
         chk($sformatf("pt3 word%0d", i), {cap_q[i].data, cap_q[i].sot, cap_q[i].eot, cap_q[i].src},
             {64'hA0 + 64'(i), (i == 0) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0});
         chk($sformatf("pt3 latency%0d", i), cap_q[i].cyc - first_pop, i + 1);
      end

      // Table vectors, listed in expected output order
      tbl[0]  = mk(0, 1, 1, 0, 64'h10, 1, 1, 1, 0);
      tbl[1]  = mk(0, 1, 0, 0, 64'h11, 1, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 64'h12, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 0, 64'h13, 1, 0, 1, 0);
      tbl[4]  = mk(0, 1, 1, 1, 64'h14, 0, 0, 0, 0);
      tbl[5]  = mk(1, 1, 0, 0, 64'h20, 1, 1, 0, 1);
      tbl[6]  = mk(1, 0, 0, 0, 64'h21, 1, 0, 0, 1);
      tbl[7]  = mk(1, 0, 0, 0, 64'h22, 1, 0, 0, 1);
      tbl[8]  = mk(1, 0, 1, 0, 64'h23, 1, 0, 1, 1);
      tbl[9]  = mk(0, 1, 0, 0, 64'h15, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 1, 0, 64'h16, 1, 0, 1, 0);
      tbl[11] = mk(0, 1, 1, 1, 64'h17, 0, 0, 0, 0);
      tbl[12] = mk(1, 1, 1, 0, 64'h24, 1, 1, 1, 1);
      tbl[13] = mk(0, 1, 0, 1, 64'h18, 1, 1, 0, 0);
      tbl[14] = mk(0, 0, 1, 1, 64'h19, 1, 0, 1, 0);
      tbl[15] = mk(0, 1, 1, 1, 64'h1A, 0, 0, 0, 0);
      tbl[16] = mk(1, 1, 0, 0, 64'h25, 1, 1, 0, 1);
      tbl[17] = mk(1, 1, 0, 0, 64'h26, 1, 0, 0, 1);
      tbl[18] = mk(1, 0, 1, 0, 64'h27, 1, 0, 1, 1);
      do_reset();
      for (int i = 0; i < 19; i++) begin
         wd = w(tbl[i].data, tbl[i].sot, tbl[i].eot, tbl[i].slot);
         if (tbl[i].lz) lz_q.push_back(wd);
         else pt_q.push_back(wd);
      end
      drive_heads();
      run_idle("table", 400);
      chk("table count", cap_q.size(), 16);
      k = 0;
      for (int i = 0; i < 19; i++) begin
         if (tbl[i].exp_fwd) begin
            if (k < cap_q.size())
               chk($sformatf("table vec%0d", i), {cap_q[k].data, cap_q[k].sot, cap_q[k].eot, cap_q[k].src},
                   {tbl[i].data, tbl[i].exp_sot, tbl[i].exp_eot, tbl[i].exp_src});
            k++;
         end
      end
      chk("table stat", stat_lz_frames, 3);
      chk("table err_pt", err_pt_sync, 0);
      chk("table err_lz", err_lz_sync, 1);

      // Backpressure across a 6-word LZ frame
      do_reset();
      pt_q.push_back(w(64'hEE, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 6; i++) lz_q.push_back(w(64'h30 + 64'(i), i == 0, i == 5, 1'b0));
      drive_heads();
      bp_pat = 4'b1001;
      bp_inflight = 0;
      bp_on = 1'b1;
      k = 0;
      while (cap_q.size() < 6 && k < 100) begin
         ob_ready = bp_pat[k % 4];
         step();
         k++;
      end
      bp_on = 1'b0;
      ob_ready = 1'b1;
      chk("bp count", cap_q.size(), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++)
         chk($sformatf("bp word%0d", i), {cap_q[i].data, cap_q[i].sot, cap_q[i].eot, cap_q[i].src},
             {64'h30 + 64'(i), i == 0 ? 1'b1 : 1'b0, i == 5 ? 1'b1 : 1'b0, 1'b1});
      chk("bp pop while full", bp_viol, 0);
      chk("bp stat", stat_lz_frames, 1);

      // LZ sync error, clear, and set winning over clear
      do_reset();
      pt_q.push_back(w(64'hEE, 1'b1, 1'b1, 1'b1));
      lz_q.push_back(w(64'h40, 1'b0, 1'b0, 1'b0));
      drive_heads();
      run_idle("lzsync", 50);
      chk("lzsync dropped", cap_q.size(), 0);
      chk("lzsync err_lz", err_lz_sync, 1);
      chk("lzsync err_pt", err_pt_sync, 0);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("clear err_lz", err_lz_sync, 0);
      lz_hold = 1'b1;
      lz_q.push_back(w(64'h41, 1'b0, 1'b0, 1'b0));
      drive_heads();
      step();
      clear_err = 1'b1;
      lz_hold = 1'b0;
      drive_heads();
      step();
      clear_err = 1'b0;
      chk("set beats clear", err_lz_sync, 1);
      chk("set beats clear popped", lz_q.size(), 0);
      lz_q.push_back(w(64'h42, 1'b1, 1'b1, 1'b0));
      drive_heads();
      run_idle("lzsync good", 50);
      chk("lzsync good count", cap_q.size(), 1);
      if (cap_q.size() > 0)
         chk("lzsync good word", {cap_q[0].data, cap_q[0].sot, cap_q[0].eot, cap_q[0].src}, {64'h42, 3'b111});
      chk("lzsync stat", stat_lz_frames, 1);

      // Pass-through word without sot in PT_SOT
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      pt_q.push_back(w(64'h50, 1'b0, 1'b1, 1'b0));
      pt_q.push_back(w(64'h51, 1'b1, 1'b1, 1'b0));
      drive_heads();
      run_idle("ptsync", 50);
      chk("ptsync err_pt", err_pt_sync, 1);
      chk("ptsync count", cap_q.size(), 2);
      if (cap_q.size() > 1)
         chk("ptsync word", {cap_q[1].data, cap_q[1].sot, cap_q[1].eot, cap_q[1].src}, {64'h51, 3'b110});

      // Counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 17; i++) begin
         pt_q.push_back(w(64'hF00, 1'b1, 1'b1, 1'b1));
         lz_q.push_back(w(64'(i), 1'b1, 1'b1, 1'b0));
      end
      drive_heads();
      run_idle("wrap", 500);
      chk("wrap count", cap_q.size(), 17);
      chk("wrap stat16", stat_lz_frames, 17);
      chk("wrap stat4", stat4, 1);

      // Reset in the middle of an LZ frame
      do_reset();
      pt_q.push_back(w(64'hEE, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 5; i++) lz_q.push_back(w(64'h60 + 64'(i), i == 0, i == 4, 1'b0));
      drive_heads();
      k = 0;
      while (lz_q.size() > 3 && k < 50) begin
         step();
         k++;
      end
      chk("midrst pops", lz_q.size(), 3);
      rst_n = 1'b0;
      #1;
      chk("midrst ob_valid", ob_valid, 0);
      chk("midrst ob_fields", {ob_data, ob_sot, ob_eot, ob_src}, 0);
      chk("midrst lz_rd", lz_rd, 0);
      prev_stall = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      cap_q.delete();
      pt_q.push_back(w(64'h70, 1'b1, 1'b1, 1'b0));
      drive_heads();
      repeat (8) step();
      chk("postrst count", cap_q.size(), 1);
      if (cap_q.size() > 0)
         chk("postrst word", {cap_q[0].data, cap_q[0].sot, cap_q[0].eot, cap_q[0].src}, {64'h70, 3'b110});
      chk("postrst lz untouched", lz_q.size(), 3);
      chk("postrst stat", stat_lz_frames, 0);

      chk("held under stall", stab_viol, 0);
      chk("both pops", both_viol, 0);
      chk("cnt4 instance agrees", mirror_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
